// File: rtl/ray_generator_pkg.sv
// State encoding for the ray generator frame/pixel sequencer.
package ray_generator_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_NORM,
    S_PRESENT,
    S_ADVANCE,
    S_DONE
  } rg_state_e;

endpackage

// File: rtl/vector_pkg.sv
// Fixed-point vector helpers shared by the ray pipeline stages.
// fp is signed Q8.24; vec3 packs {x, y, z} with x in the most significant word.
// Also carries the state encoding of the Newton 1/sqrt iterator.
package vector_pkg;

  typedef logic signed [31:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  localparam fp FP_ONE        = 32'h01000000;
  localparam fp FP_HALF       = 32'h00800000;
  localparam fp FP_THREE_HALF = 32'h01800000;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_SQUARE,
    RS_UPDATE
  } rsqrt_state_e;

  // Q8.24 multiply: full 64-bit signed product, keep bits [55:24] (truncated).
  function automatic fp fp_mul(input fp a, input fp b);
    logic signed [63:0] p;
    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return fp'(p >>> 24);
  endfunction

  function automatic fp fp_add(input fp a, input fp b);
    return a + b;
  endfunction

  function automatic vec3 vec3_scale(input vec3 v, input fp k);
    vec3 r;
    r.x = fp_mul(v.x, k);
    r.y = fp_mul(v.y, k);
    r.z = fp_mul(v.z, k);
    return r;
  endfunction

endpackage

// File: rtl/fp_rsqrt_newton.sv
// Iterative 1/sqrt(s) in Q8.24 by Newton-Raphson from y0 = 1.0.
// Each iteration y = y*(1.5 - 0.5*s*y*y) takes two cycles (square, update).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load s and begin (ignored while iterating)
//   s          : Q8.24 operand, sampled on start; expected in [1,2)
//   y          : Q8.24 result register
//   done       : one-cycle pulse, y holds the final value while it is high
module fp_rsqrt_newton
  import vector_pkg::*;
#(
  parameter int unsigned NR_ITERS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] s,
  output logic [31:0] y,
  output logic        done
);

  localparam int unsigned IW = $clog2(NR_ITERS + 1);

  rsqrt_state_e    state_q, state_d;
  fp               s_q, s_d;
  fp               y_q, y_d;
  fp               yy_q, yy_d;
  logic [IW-1:0]   it_q, it_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RS_IDLE;
      s_q     <= '0;
      y_q     <= '0;
      yy_q    <= '0;
      it_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      y_q     <= y_d;
      yy_q    <= yy_d;
      it_q    <= it_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    y_d     = y_q;
    yy_d    = yy_q;
    it_d    = it_q;
    done_d  = 1'b0;
    unique case (state_q)
      RS_IDLE: begin
        if (start) begin
          s_d     = fp'(s);
          y_d     = FP_ONE;
          it_d    = '0;
          state_d = RS_SQUARE;
        end
      end
      RS_SQUARE: begin
        yy_d    = fp_mul(y_q, y_q);
        state_d = RS_UPDATE;
      end
      RS_UPDATE: begin
        y_d = fp_mul(y_q, FP_THREE_HALF - fp_mul(fp_mul(FP_HALF, s_q), yy_q));
        if (it_q == IW'(NR_ITERS - 1)) begin
          done_d  = 1'b1;
          state_d = RS_IDLE;
        end else begin
          it_d    = it_q + 1'b1;
          state_d = RS_SQUARE;
        end
      end
      default: state_d = RS_IDLE;
    endcase
  end

  assign y    = y_q;
  assign done = done_q;

endmodule

// File: rtl/ray_generator.sv
// Camera ray generator: scans IMG_W x IMG_H pixels in raster order and emits
// one ray per pixel (origin CAM_POS, unit direction) on a valid/ready port.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   frame_start      : pulse, starts a frame from IDLE only
//   ray_valid/ready  : output handshake
//   ray_origin       : CAM_POS while ray_valid, else 0
//   ray_dir          : normalised {u*y, v*y, y}, y = 1/sqrt(u^2+v^2+1)
//   pixel_x/pixel_y  : pixel of the current ray
//   busy             : high from leaving IDLE until DONE is left
//   frame_done       : pulse after the last ray is accepted
module ray_generator
  import vector_pkg::*;
  import ray_generator_pkg::*;
#(
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 48,
  parameter fp           PIX_STEP = 32'h00055555,
  parameter vec3         CAM_POS  = '0,
  parameter int unsigned NR_ITERS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  output logic                       ray_valid,
  input  logic                       ray_ready,
  output logic [95:0]                ray_origin,
  output logic [95:0]                ray_dir,
  output logic [$clog2(IMG_W)-1:0]   pixel_x,
  output logic [$clog2(IMG_H)-1:0]   pixel_y,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  rg_state_e      state_q, state_d;
  logic [XW-1:0]  px_q, px_d;
  logic [YW-1:0]  py_q, py_d;
  fp              u_q, u_d;
  fp              v_q, v_d;
  vec3            dir_q, dir_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           fdone_q, fdone_d;

  logic signed [31:0] dx_c, dy_c;
  fp              u_c, v_c, s_c;
  vec3            base_c;
  logic           last_pix;

  logic           rs_start;
  logic [31:0]    rs_y;
  logic           rs_done;

  // Integer pixel offsets times PIX_STEP are exact in Q8.24, so a plain
  // 32-bit product is used rather than fp_mul.
  always_comb begin
    dx_c = 32'(px_q) - 32'(IMG_W / 2);
    dy_c = 32'(IMG_H / 2) - 32'(py_q);
    u_c  = dx_c * PIX_STEP;
    v_c  = dy_c * PIX_STEP;
    s_c  = fp_add(fp_add(fp_mul(u_c, u_c), fp_mul(v_c, v_c)), FP_ONE);
  end

  // s is handed over combinationally in SETUP so the iterator starts at once;
  // its done pulse then lines up with the last NORM cycle.
  fp_rsqrt_newton #(
    .NR_ITERS(NR_ITERS)
  ) u_rsqrt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (rs_start),
    .s     (s_c),
    .y     (rs_y),
    .done  (rs_done)
  );

  assign last_pix = (px_q == XW'(IMG_W - 1)) && (py_q == YW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      px_q    <= '0;
      py_q    <= '0;
      u_q     <= '0;
      v_q     <= '0;
      dir_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      u_q     <= u_d;
      v_q     <= v_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    u_d      = u_q;
    v_d      = v_q;
    dir_d    = dir_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    fdone_d  = 1'b0;
    rs_start = 1'b0;
    base_c   = '0;
    base_c.x = u_q;
    base_c.y = v_q;
    base_c.z = FP_ONE;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          px_d    = '0;
          py_d    = '0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        u_d      = u_c;
        v_d      = v_c;
        rs_start = 1'b1;
        state_d  = S_NORM;
      end
      S_NORM: begin
        if (rs_done) begin
          dir_d   = vec3_scale(base_c, fp'(rs_y));
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (ray_ready) begin
          valid_d = 1'b0;
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (last_pix) begin
          px_d    = '0;
          py_d    = '0;
          fdone_d = 1'b1;
          state_d = S_DONE;
        end else begin
          if (px_q == XW'(IMG_W - 1)) begin
            px_d = '0;
            py_d = py_q + 1'b1;
          end else begin
            px_d = px_q + 1'b1;
          end
          state_d = S_SETUP;
        end
      end
      S_DONE: begin
        px_d    = '0;
        py_d    = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ray_valid  = valid_q;
  assign ray_dir    = dir_q;
  assign ray_origin = valid_q ? CAM_POS : '0;
  assign pixel_x    = px_q;
  assign pixel_y    = py_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_ray_generator.sv
// Scoreboard bench for ray_generator: stimulus pushes expected pixels, a
// negedge monitor pops and checks every accepted ray against a real-valued
// reference direction.
module tb_ray_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        ray_ready = 1'b0;
  logic        ray_valid;
  logic [95:0] ray_origin;
  logic [95:0] ray_dir;
  logic [5:0]  pixel_x;
  logic [5:0]  pixel_y;
  logic        busy;
  logic        frame_done;

  ray_generator #(
    .IMG_W    (64),
    .IMG_H    (48),
    .PIX_STEP (32'h00055555),
    .CAM_POS  (96'h0),
    .NR_ITERS (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .ray_valid   (ray_valid),
    .ray_ready   (ray_ready),
    .ray_origin  (ray_origin),
    .ray_dir     (ray_dir),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int accepts = 0;
  int last_acc = 0;
  int fd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input string act, input string req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  function automatic real fp2r(input logic [31:0] a);
    return $itor($signed(a)) / 16777216.0;
  endfunction

  function automatic real rabs(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  function automatic bit outs_zero();
    return !ray_valid && ray_origin == 96'h0 && ray_dir == 96'h0 &&
           pixel_x == 6'd0 && pixel_y == 6'd0 && !busy && !frame_done;
  endfunction

  function automatic string outs_str();
    return $sformatf("valid=%0b org=%h dir=%h x=%0d y=%0d busy=%0b done=%0b",
                     ray_valid, ray_origin, ray_dir, pixel_x, pixel_y, busy, frame_done);
  endfunction

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.x = i % 64;
      e.y = i / 64;
      sb.push_back(e);
    end
  endtask

  // Reference: exact Q8.24 pixel offsets, double-precision normalisation.
  task automatic check_ray(input exp_t e);
    real step, u, v, y, rx, ry, rz, dx, dy, dz, n2;
    step = 349525.0 / 16777216.0;
    u  = (e.x - 32) * step;
    v  = (24 - e.y) * step;
    y  = 1.0 / $sqrt(1.0 + u * u + v * v);
    rx = u * y;
    ry = v * y;
    rz = y;
    dx = fp2r(ray_dir[95:64]);
    dy = fp2r(ray_dir[63:32]);
    dz = fp2r(ray_dir[31:0]);
    chk(pixel_x == e.x[5:0] && pixel_y == e.y[5:0], "raster_order",
        $sformatf("(%0d,%0d)", pixel_x, pixel_y), $sformatf("(%0d,%0d)", e.x, e.y));
    chk(ray_origin == 96'h0, "origin", $sformatf("%h", ray_origin), "0");
    chk(rabs(dx - rx) <= 1.0 / 65536.0 && rabs(dy - ry) <= 1.0 / 65536.0 &&
        rabs(dz - rz) <= 1.0 / 65536.0, "dir_ref",
        $sformatf("(%0d,%0d) {%f,%f,%f}", e.x, e.y, dx, dy, dz),
        $sformatf("{%f,%f,%f}", rx, ry, rz));
    n2 = dx * dx + dy * dy + dz * dz;
    chk(rabs(n2 - 1.0) <= 1.0 / 16384.0, "dir_norm",
        $sformatf("(%0d,%0d) %f", e.x, e.y, n2), "1.0");
    if (e.x == 32 && e.y == 24)
      chk(ray_dir == {32'h0, 32'h0, 32'h01000000}, "centre_exact",
          $sformatf("%h", ray_dir), "000000000000000001000000");
  endtask

  always @(negedge clk) begin
    if (rst_n && ray_valid && ray_ready) begin
      accepts++;
      last_acc = cyc;
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_ray", $sformatf("(%0d,%0d)", pixel_x, pixel_y), "no ray");
      end else begin
        mon_e = sb.pop_front();
        check_ray(mon_e);
      end
    end
    if (rst_n && frame_done) begin
      fd_cnt++;
      chk(cyc - last_acc == 2, "done_delay", $sformatf("%0d", cyc - last_acc), "2");
      chk(busy == 1'b1, "busy_in_done", $sformatf("%0b", busy), "1");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1500000;
    bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, a0;
    bit seen;
    logic [95:0] snap_dir, snap_org;
    logic [5:0]  snap_x, snap_y;

    // Reset with random inputs.
    for (int i = 0; i < 5; i++) begin
      frame_start = 1'($urandom_range(0, 1));
      ray_ready   = 1'($urandom_range(0, 1));
      tick();
      chk(outs_zero(), "reset_outputs", outs_str(), "all zero");
    end
    frame_start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ray_ready = 1'($urandom_range(0, 1));
      tick();
      chk(!ray_valid && !busy, "idle_after_reset", outs_str(), "valid=0 busy=0");
    end
    ray_ready = 1'b0;

    // Frame A: full frame, first ray back-pressured, stray frame_start pulses.
    a0 = accepts;
    push_frame(3072);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk(busy && pixel_x == 6'd0 && pixel_y == 6'd0, "start_busy", outs_str(), "busy=1 x=0 y=0");
    lat = 0;
    while (!ray_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk(lat == 10, "latency", $sformatf("%0d", lat), "10");
    snap_dir = ray_dir;
    snap_org = ray_origin;
    snap_x   = pixel_x;
    snap_y   = pixel_y;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk(ray_valid && ray_dir == snap_dir && ray_origin == snap_org &&
          pixel_x == snap_x && pixel_y == snap_y, "backpressure_hold", outs_str(),
          $sformatf("valid=1 dir=%h x=%0d y=%0d", snap_dir, snap_x, snap_y));
    end
    chk(accepts == a0, "no_accept_when_stalled", $sformatf("%0d", accepts - a0), "0");
    ray_ready = 1'b1;
    tick();
    chk(accepts == a0 + 1 && !ray_valid, "single_accept",
        $sformatf("accepts=%0d valid=%0b", accepts - a0, ray_valid), "accepts=1 valid=0");

    repeat (200) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (537) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;

    n = 0;
    while (!frame_done && n < 40000) begin
      tick();
      n++;
    end
    chk(frame_done == 1'b1, "frame_done_seen", $sformatf("%0b", frame_done), "1");
    // frame_start coinciding with DONE must be ignored.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk(!busy && !frame_done, "busy_drop", outs_str(), "busy=0 done=0");
    chk(fd_cnt == 1, "done_once", $sformatf("%0d", fd_cnt), "1");
    chk(accepts - a0 == 3072, "ray_count", $sformatf("%0d", accepts - a0), "3072");
    chk(sb.size() == 0, "sb_empty", $sformatf("%0d", sb.size()), "0");
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy || ray_valid) seen = 1'b1;
    end
    chk(!seen, "start_in_done_ignored", $sformatf("%0b", seen), "0");

    // Frame B: asynchronous reset at pixel (10,5).
    push_frame(3072);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (!(ray_valid && pixel_x == 6'd10 && pixel_y == 6'd5) && n < 10000) begin
      tick();
      n++;
    end
    chk(ray_valid && pixel_x == 6'd10 && pixel_y == 6'd5, "reach_10_5", outs_str(), "valid at (10,5)");
    a0 = fd_cnt;
    rst_n = 1'b0;
    #1;
    chk(outs_zero(), "async_reset_midframe", outs_str(), "all zero");
    sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk(fd_cnt == a0 && !busy && !ray_valid, "no_done_after_reset",
        $sformatf("done_pulses=%0d %s", fd_cnt - a0, outs_str()), "done_pulses=0 busy=0 valid=0");

    // Frame C: restart begins at (0,0).
    push_frame(3);
    a0 = accepts;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk(busy && pixel_x == 6'd0 && pixel_y == 6'd0, "restart_origin", outs_str(), "busy=1 x=0 y=0");
    n = 0;
    while (accepts < a0 + 3 && n < 200) begin
      tick();
      n++;
    end
    chk(accepts == a0 + 3, "restart_rays", $sformatf("%0d", accepts - a0), "3");
    rst_n = 1'b0;
    tick();
    chk(sb.size() == 0, "restart_sb_empty", $sformatf("%0d", sb.size()), "0");
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
